lzd_norm_pipe: RTL

//  Parametrised, pipelined leading-zero detector and normaliser with valid/ready handshake.

---
 rtl/lzd_norm_pipe_pkg.sv | 17 +
 rtl/lzd_norm_pipe_tree.sv | 41 ++++
 rtl/lzd_norm_pipe.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lzd_norm_pipe_pkg.sv
// Shared constants and elaboration helpers for the leading-zero detect / normalise pipeline.
package lzd_pkg;

  // Operand slice handled by one first-level LZD when the count is split over two stages.
  localparam int GRP_W     = 8;
  localparam int DEF_WIDTH = 64;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  localparam int DEF_CNT_W = clog2(DEF_WIDTH);
  localparam int GRP_CNT_W = clog2(GRP_W);

endpackage

// File: rtl/lzd_norm_pipe_tree.sv
// Combinational recursive leading-zero detector for a power-of-two width W >= 2.
// An all-zero input yields vld_o = 0 and cnt_o = all ones.
module lzd_tree
  import lzd_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]         data_i,
  output logic [$clog2(W)-1:0] cnt_o,
  output logic                 vld_o
);

  if (W == 2) begin : g_leaf
    assign vld_o = |data_i;
    assign cnt_o = ~data_i[1];
  end else begin : g_node
    localparam int HW = W / 2;

    logic [$clog2(HW)-1:0] cnt_hi;
    logic [$clog2(HW)-1:0] cnt_lo;
    logic                  vld_hi;
    logic                  vld_lo;

    lzd_tree #(.W(HW)) u_hi (
      .data_i (data_i[W-1:HW]),
      .cnt_o  (cnt_hi),
      .vld_o  (vld_hi)
    );

    lzd_tree #(.W(HW)) u_lo (
      .data_i (data_i[HW-1:0]),
      .cnt_o  (cnt_lo),
      .vld_o  (vld_lo)
    );

    // Upper half wins whenever it holds a set bit; otherwise skip it entirely.
    assign vld_o = vld_hi | vld_lo;
    assign cnt_o = vld_hi ? {1'b0, cnt_hi} : {1'b1, cnt_lo};
  end

endmodule

// File: rtl/lzd_norm_pipe.sv
// Pipelined leading-zero count and left-normalise with a valid/ready handshake.
// Stages form a collapsing pipeline: a stage loads whenever it is empty or its content moves on.
module lzd_norm_pipe
  import lzd_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int STAGES  = 2,
  parameter int NORM_EN = 1,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_cnt,
  output logic                     out_zero,
  output logic [WIDTH-1:0]         out_norm,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int CNT_W = clog2(WIDTH);
  localparam int NG    = WIDTH / GRP_W;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] ld;

  logic [WIDTH-1:0]  sh_data;
  logic [CNT_W-1:0]  sh_cnt;
  logic [WIDTH-1:0]  sh_norm;

  // Load enables ripple back from the output so bubbles collapse in a single cycle.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = ~st_q[STAGES-1].valid | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ld[k] = ~st_q[k].valid | ld[k+1];
    end
  end

  assign in_ready = ld[0];

  if (NORM_EN != 0) begin : g_norm
    assign sh_norm = sh_data << sh_cnt;
  end else begin : g_no_norm
    assign sh_norm = '0;
  end

  if (STAGES == 1) begin : g_s1
    logic [CNT_W-1:0] full_cnt;
    logic             full_vld;

    lzd_tree #(.W(WIDTH)) u_tree (
      .data_i (in_data),
      .cnt_o  (full_cnt),
      .vld_o  (full_vld)
    );

    assign sh_data  = in_data;
    assign sh_cnt   = full_cnt;
    assign st_d[0]  = {in_valid, sh_norm, full_cnt, ~full_vld, in_tag};
  end else if (STAGES == 2) begin : g_s2
    logic [CNT_W-1:0] full_cnt;
    logic             full_vld;

    lzd_tree #(.W(WIDTH)) u_tree (
      .data_i (in_data),
      .cnt_o  (full_cnt),
      .vld_o  (full_vld)
    );

    assign st_d[0]  = {in_valid, in_data, full_cnt, ~full_vld, in_tag};
    assign sh_data  = st_q[0].data;
    assign sh_cnt   = st_q[0].cnt;
    assign st_d[1]  = {st_q[0].valid, sh_norm, st_q[0].cnt, st_q[0].zero, st_q[0].tag};
  end else begin : g_s3
    logic [NG-1:0][GRP_CNT_W-1:0] grp_cnt;
    logic [NG-1:0][GRP_CNT_W-1:0] grp_cnt_q;
    logic [NG-1:0]                grp_vld;
    logic [NG-1:0]                grp_vld_q;
    logic [CNT_W-1:0]             merge_cnt;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      lzd_tree #(.W(GRP_W)) u_grp (
        .data_i (in_data[gi*GRP_W +: GRP_W]),
        .cnt_o  (grp_cnt[gi]),
        .vld_o  (grp_vld[gi])
      );
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        grp_cnt_q <= '0;
        grp_vld_q <= '0;
      end else if (ld[0] && in_valid) begin
        grp_cnt_q <= grp_cnt;
        grp_vld_q <= grp_vld;
      end
    end

    // Highest group with a set bit wins; the all-zero default lands on WIDTH-1.
    always_comb begin
      merge_cnt = CNT_W'((NG - 1) * GRP_W) + CNT_W'(grp_cnt_q[0]);
      for (int g = 0; g < NG; g++) begin
        if (grp_vld_q[g]) begin
          merge_cnt = CNT_W'((NG - 1 - g) * GRP_W) + CNT_W'(grp_cnt_q[g]);
        end
      end
    end

    assign st_d[0]  = {in_valid, in_data, {CNT_W{1'b0}}, 1'b0, in_tag};
    assign st_d[1]  = {st_q[0].valid, st_q[0].data, merge_cnt, ~|grp_vld_q, st_q[0].tag};
    assign sh_data  = st_q[1].data;
    assign sh_cnt   = st_q[1].cnt;
    assign st_d[2]  = {st_q[1].valid, sh_norm, st_q[1].cnt, st_q[1].zero, st_q[1].tag};
  end

  // Payload only changes when a real operand arrives, so idle inputs never reach the outputs.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q[gi] <= '0;
      end else if (ld[gi]) begin
        if (st_d[gi].valid) begin
          st_q[gi] <= st_d[gi];
        end else begin
          st_q[gi].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = st_q[STAGES-1].valid;
  assign out_cnt   = st_q[STAGES-1].cnt;
  assign out_zero  = st_q[STAGES-1].zero;
  assign out_norm  = st_q[STAGES-1].data;
  assign out_tag   = st_q[STAGES-1].tag;

endmodule
